// File: rtl/param_bank_pkg.sv
// Shared types and constants for the double-buffered parameter bank controller.
package param_bank_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RESP,
        ST_WAIT
    } state_t;

    // Bit of the commit-address write data that requests a commit
    localparam int COMMIT_BIT = 0;

    localparam logic RSP_OK  = 1'b0;
    localparam logic RSP_ERR = 1'b1;

endpackage

// File: rtl/param_bank_controller.sv
// Double-buffered register bank: host commands fill the shadow bank, a commit copies it into the
// active bank either at once or at the next frame boundary, so the datapath sees one set per frame.
module param_bank_controller
    import param_bank_pkg::*;
#(
    parameter int                             ADDR_W      = 16,
    parameter int                             DATA_W      = 32,
    parameter int                             REG_W       = 18,
    parameter int                             NUM_REGS    = 64,
    parameter logic [ADDR_W-1:0]              BASE_ADDR   = '0,
    parameter logic [ADDR_W-1:0]              COMMIT_ADDR = 'h00FF,
    parameter bit                             COMMIT_MODE = 1'b1,
    parameter logic [NUM_REGS-1:0][REG_W-1:0] DEFAULTS    = '0
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             cmd_valid_i,
    output logic                             cmd_ready_o,
    input  logic                             cmd_write_i,
    input  logic [ADDR_W-1:0]                cmd_addr_i,
    input  logic [DATA_W-1:0]                cmd_data_i,
    output logic                             rsp_valid_o,
    output logic [DATA_W-1:0]                rsp_data_o,
    output logic                             rsp_err_o,
    input  logic                             frame_start_i,
    output logic [NUM_REGS-1:0][REG_W-1:0]   regs_o,
    output logic                             commit_pending_o,
    output logic                             update_o
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    state_t                           state_q, state_d;
    logic [NUM_REGS-1:0][REG_W-1:0]   shadow_q;
    logic [NUM_REGS-1:0][REG_W-1:0]   active_q;
    logic                             pending_q, pending_d;
    logic                             rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]                rsp_data_q, rsp_data_d;
    logic                             rsp_err_q, rsp_err_d;
    logic                             update_q;
    logic                             do_commit;

    logic [ADDR_W-1:0]                off;
    logic [IDX_W-1:0]                 idx;
    logic                             in_range;
    logic                             is_commit;
    logic                             accept;
    logic                             commit_req;
    logic [NUM_REGS-1:0]              wr_en;

    // Range check happens on the full-width offset, so out-of-range addresses never alias by truncation
    assign off        = cmd_addr_i - BASE_ADDR;
    assign in_range   = ({1'b0, off} < (ADDR_W+1)'(NUM_REGS));
    assign idx        = off[IDX_W-1:0];
    assign is_commit  = (cmd_addr_i == COMMIT_ADDR);
    assign accept     = cmd_valid_i && (state_q == ST_IDLE);
    assign commit_req = accept && cmd_write_i && is_commit && cmd_data_i[COMMIT_BIT];

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_dec
        assign wr_en[g] = accept && cmd_write_i && in_range && (idx == IDX_W'(g));
    end

    always_comb begin
        state_d     = state_q;
        cmd_ready_o = (state_q == ST_IDLE);
        pending_d   = pending_q;
        do_commit   = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_data_d  = '0;
        rsp_err_d   = RSP_OK;

        if (COMMIT_MODE && pending_q && frame_start_i) begin
            do_commit = 1'b1;
            pending_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    if (!in_range && !is_commit) begin
                        rsp_err_d = RSP_ERR;
                    end else if (!cmd_write_i) begin
                        rsp_data_d = in_range ? DATA_W'(shadow_q[idx]) : DATA_W'(pending_q);
                    end else if (commit_req) begin
                        if (COMMIT_MODE) pending_d = 1'b1;
                        else             do_commit = 1'b1;
                    end
                end
            end
            ST_RESP: state_d = (pending_q && !frame_start_i) ? ST_WAIT : ST_IDLE;
            ST_WAIT: if (frame_start_i) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            pending_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            update_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            update_q    <= do_commit;
        end
    end

    // Banks stay flat registers: the active bank fans out to every datapath consumer
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shadow_q <= DEFAULTS;
            active_q <= DEFAULTS;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_en[i]) shadow_q[i] <= cmd_data_i[REG_W-1:0];
            end
            if (do_commit) active_q <= shadow_q;
        end
    end

    assign rsp_valid_o      = rsp_valid_q;
    assign rsp_data_o       = rsp_data_q;
    assign rsp_err_o        = rsp_err_q;
    assign regs_o           = active_q;
    assign commit_pending_o = pending_q;
    assign update_o         = update_q;

endmodule

// File: tb/tb_param_bank_controller.sv
// Directed bench for param_bank_controller: frame-synchronised instance plus an immediate-commit instance.
module tb_param_bank_controller;

    localparam int NR = 64;
    localparam int RW = 18;
    localparam logic [NR-1:0][RW-1:0] DEF =
        {{(NR-6){18'h0}}, 18'h20001, 18'h0, 18'h3C00, 18'h0, 18'h0, 18'h0};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, cmd_valid, cmd_write, frame_start, sel;
    logic [15:0] cmd_addr;
    logic [31:0] cmd_data;

    logic                  rdy1, rv1, re1, pend1, upd1;
    logic [31:0]           rd1;
    logic [NR-1:0][RW-1:0] regs1;
    logic                  rdy0, rv0, re0, pend0, upd0;
    logic [31:0]           rd0;
    logic [NR-1:0][RW-1:0] regs0;

    wire v1 = cmd_valid & ~sel;
    wire v0 = cmd_valid & sel;
    wire        rdy = sel ? rdy0 : rdy1;
    wire        rv  = sel ? rv0  : rv1;
    wire        re  = sel ? re0  : re1;
    wire [31:0] rd  = sel ? rd0  : rd1;

    param_bank_controller #(.COMMIT_MODE(1'b1), .DEFAULTS(DEF)) dut1 (
        .clk_i(clk), .rst_i(rst), .cmd_valid_i(v1), .cmd_ready_o(rdy1),
        .cmd_write_i(cmd_write), .cmd_addr_i(cmd_addr), .cmd_data_i(cmd_data),
        .rsp_valid_o(rv1), .rsp_data_o(rd1), .rsp_err_o(re1), .frame_start_i(frame_start),
        .regs_o(regs1), .commit_pending_o(pend1), .update_o(upd1));

    param_bank_controller #(.COMMIT_MODE(1'b0), .DEFAULTS(DEF)) dut0 (
        .clk_i(clk), .rst_i(rst), .cmd_valid_i(v0), .cmd_ready_o(rdy0),
        .cmd_write_i(cmd_write), .cmd_addr_i(cmd_addr), .cmd_data_i(cmd_data),
        .rsp_valid_o(rv0), .rsp_data_o(rd0), .rsp_err_o(re0), .frame_start_i(frame_start),
        .regs_o(regs0), .commit_pending_o(pend0), .update_o(upd0));

    int nvec = 0;
    int nerr = 0;
    int upd_cnt1 = 0;

    always @(negedge clk) if (upd1) upd_cnt1++;

    typedef struct {
        logic        w;
        logic [15:0] a;
        logic [31:0] d;
        logic [31:0] ed;
        logic        ee;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of cycle T+1 after the accept edge.
    task automatic issue(input string nm, input logic w, input logic [15:0] a, input logic [31:0] d);
        int n = 0;
        while (!rdy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!rdy) chk({nm, "_ready_timeout"}, {31'b0, rdy}, 32'd1);
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_data = d;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic do_cmd(input string nm, input logic w, input logic [15:0] a, input logic [31:0] d,
                          input logic [31:0] ed, input logic ee);
        issue(nm, w, a, d);
        chk({nm, "_vld"},  {31'b0, rv},  32'd1);
        chk({nm, "_data"}, rd, ed);
        chk({nm, "_err"},  {31'b0, re},  {31'b0, ee});
        chk({nm, "_rdy"},  {31'b0, rdy}, 32'd0);
        @(negedge clk);
        chk({nm, "_vld_off"}, {31'b0, rv}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{1'b1, 16'h0003, 32'h0000_1234, 32'h0,       1'b0};
        tbl[1]  = '{1'b0, 16'h0003, 32'h0,         32'h1234,    1'b0};
        tbl[2]  = '{1'b0, 16'h0005, 32'h0,         32'h20001,   1'b0};
        tbl[3]  = '{1'b1, 16'h0005, 32'hFFFF_FFFF, 32'h0,       1'b0};
        tbl[4]  = '{1'b0, 16'h0005, 32'h0,         32'h3FFFF,   1'b0};
        tbl[5]  = '{1'b1, 16'h0040, 32'h0000_AAAA, 32'h0,       1'b1};
        tbl[6]  = '{1'b0, 16'h0040, 32'h0,         32'h0,       1'b1};
        tbl[7]  = '{1'b0, 16'hFFFF, 32'h0,         32'h0,       1'b1};
        tbl[8]  = '{1'b0, 16'h003F, 32'h0,         32'h0,       1'b0};
        tbl[9]  = '{1'b1, 16'h003F, 32'h0002_5A5A, 32'h0,       1'b0};
        tbl[10] = '{1'b0, 16'h003F, 32'h0,         32'h25A5A,   1'b0};
        tbl[11] = '{1'b0, 16'h00FF, 32'h0,         32'h0,       1'b0};
        tbl[12] = '{1'b1, 16'h00FF, 32'h0,         32'h0,       1'b0};
        tbl[13] = '{1'b0, 16'h0000, 32'h0,         32'h0,       1'b0};

        rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_data = '0;
        frame_start = 1'b0; sel = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        chk("rst_ready",  {31'b0, rdy1},  32'd1);
        chk("rst_vld",    {31'b0, rv1},   32'd0);
        chk("rst_data",   rd1,            32'd0);
        chk("rst_err",    {31'b0, re1},   32'd0);
        chk("rst_pend",   {31'b0, pend1}, 32'd0);
        chk("rst_upd",    {31'b0, upd1},  32'd0);
        chk("rst_reg3",   {14'b0, regs1[3]}, 32'h3C00);
        chk("rst_reg3_m0", {14'b0, regs0[3]}, 32'h3C00);

        for (int i = 0; i < 14; i++)
            do_cmd($sformatf("v%0d", i), tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].ed, tbl[i].ee);

        chk("shadow_only_reg3", {14'b0, regs1[3]}, 32'h3C00);
        chk("shadow_only_reg5", {14'b0, regs1[5]}, 32'h20001);
        chk("no_update_yet", upd_cnt1, 0);

        // Commit armed, frame pulse in cycle T+5
        issue("cA", 1'b1, 16'h00FF, 32'h1);
        chk("cA_t1_vld",  {31'b0, rv1},   32'd1);
        chk("cA_t1_pend", {31'b0, pend1}, 32'd1);
        chk("cA_t1_rdy",  {31'b0, rdy1},  32'd0);
        for (int k = 2; k <= 5; k++) begin
            @(negedge clk);
            chk($sformatf("cA_t%0d_pend", k), {31'b0, pend1}, 32'd1);
            chk($sformatf("cA_t%0d_rdy", k),  {31'b0, rdy1},  32'd0);
            chk($sformatf("cA_t%0d_upd", k),  {31'b0, upd1},  32'd0);
        end
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        chk("cA_t6_reg3",  {14'b0, regs1[3]},  32'h1234);
        chk("cA_t6_reg5",  {14'b0, regs1[5]},  32'h3FFFF);
        chk("cA_t6_reg63", {14'b0, regs1[63]}, 32'h25A5A);
        chk("cA_t6_upd",   {31'b0, upd1},  32'd1);
        chk("cA_t6_rdy",   {31'b0, rdy1},  32'd1);
        chk("cA_t6_pend",  {31'b0, pend1}, 32'd0);
        @(negedge clk);
        chk("cA_t7_upd", {31'b0, upd1}, 32'd0);

        // Frame pulse in the accept cycle is ignored
        do_cmd("wB", 1'b1, 16'h0003, 32'h0777, 32'h0, 1'b0);
        frame_start = 1'b1;
        issue("cB", 1'b1, 16'h00FF, 32'h1);
        frame_start = 1'b0;
        chk("cB_t1_pend", {31'b0, pend1}, 32'd1);
        chk("cB_t1_upd",  {31'b0, upd1},  32'd0);
        chk("cB_t1_reg3", {14'b0, regs1[3]}, 32'h1234);
        @(negedge clk);
        chk("cB_t2_upd",  {31'b0, upd1},  32'd0);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        chk("cB_t3_upd",  {31'b0, upd1},  32'd1);
        chk("cB_t3_reg3", {14'b0, regs1[3]}, 32'h0777);
        chk("cB_t3_pend", {31'b0, pend1}, 32'd0);
        chk("cB_t3_rdy",  {31'b0, rdy1},  32'd1);

        // Frame pulse during the response cycle commits and skips WAIT
        do_cmd("wC", 1'b1, 16'h0003, 32'h0ABC, 32'h0, 1'b0);
        issue("cC", 1'b1, 16'h00FF, 32'h1);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        chk("cC_t2_upd",  {31'b0, upd1}, 32'd1);
        chk("cC_t2_reg3", {14'b0, regs1[3]}, 32'h0ABC);
        chk("cC_t2_rdy",  {31'b0, rdy1}, 32'd1);

        // Frame pulse with nothing pending
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        chk("fD_upd",  {31'b0, upd1}, 32'd0);
        chk("fD_reg3", {14'b0, regs1[3]}, 32'h0ABC);

        // Reset while waiting for a frame drops the commit
        do_cmd("wE", 1'b1, 16'h0003, 32'h0111, 32'h0, 1'b0);
        issue("cE", 1'b1, 16'h00FF, 32'h1);
        @(negedge clk);
        chk("cE_wait_rdy",  {31'b0, rdy1},  32'd0);
        chk("cE_wait_pend", {31'b0, pend1}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rE_pend", {31'b0, pend1}, 32'd0);
        chk("rE_rdy",  {31'b0, rdy1},  32'd1);
        chk("rE_upd",  {31'b0, upd1},  32'd0);
        chk("rE_reg3", {14'b0, regs1[3]}, 32'h3C00);
        chk("rE_reg5", {14'b0, regs1[5]}, 32'h20001);
        do_cmd("rE_rd3", 1'b0, 16'h0003, 32'h0, 32'h3C00, 1'b0);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        chk("rE_frame_upd", {31'b0, upd1}, 32'd0);

        // Immediate-commit instance
        sel = 1'b1;
        do_cmd("m0w", 1'b1, 16'h0007, 32'h0155, 32'h0, 1'b0);
        chk("m0_pre_reg7", {14'b0, regs0[7]}, 32'h0);
        issue("m0c1", 1'b1, 16'h00FF, 32'h1);
        chk("m0c1_upd",  {31'b0, upd0},  32'd1);
        chk("m0c1_reg7", {14'b0, regs0[7]}, 32'h0155);
        chk("m0c1_reg3", {14'b0, regs0[3]}, 32'h3C00);
        chk("m0c1_pend", {31'b0, pend0}, 32'd0);
        @(negedge clk);
        chk("m0c1_t2_upd", {31'b0, upd0}, 32'd0);
        chk("m0c1_t2_rdy", {31'b0, rdy0}, 32'd1);
        issue("m0c2", 1'b1, 16'h00FF, 32'h1);
        chk("m0c2_upd",  {31'b0, upd0}, 32'd1);
        chk("m0c2_reg7", {14'b0, regs0[7]}, 32'h0155);
        @(negedge clk);
        issue("m0c3", 1'b1, 16'h00FF, 32'h2);
        chk("m0c3_noop_upd", {31'b0, upd0}, 32'd0);
        chk("m0c3_noop_err", {31'b0, re0},  32'd0);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
